// File: rtl/fft_serializer.sv
// ----------------------------------------------------------------------------
// fft_serializer
//   Output stage of the 16-point FFT datapath. On a one-cycle load strobe it
//   captures a 32-word frame (words 0-15 real, 16-31 imaginary) into a register
//   buffer. It then streams the frame out one word per beat over a valid/ready
//   link. A load that arrives together with the final beat starts the next
//   frame with no idle cycle between frames. A load at any other time while a
//   frame is draining is dropped, and the sticky overrun flag is set.
//
// Configuration macro: FFT_SER_BITREV_EN
//   defined   : each 16-word half is emitted in bit-reversed bin order
//               (real half first, then imaginary half)
//   undefined : words are emitted in port order datain0..datain31
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   asynchronous, active-low reset
//   load         in   frame capture strobe
//   datain0..31  in   DW-bit frame words
//   out_ready    in   downstream accepts dataout this cycle
//   dataout      out  current output word (0 when not valid)
//   out_valid    out  dataout holds a valid word
//   frame_start  out  valid word is word 0 of the frame
//   frame_end    out  valid word is word 31 of the frame
//   busy         out  frame held and not fully drained
//   overrun      out  sticky: a load was dropped during a frame
// ----------------------------------------------------------------------------
module fft_serializer #(
    parameter int unsigned DW = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [DW-1:0] datain0,
    input  logic [DW-1:0] datain1,
    input  logic [DW-1:0] datain2,
    input  logic [DW-1:0] datain3,
    input  logic [DW-1:0] datain4,
    input  logic [DW-1:0] datain5,
    input  logic [DW-1:0] datain6,
    input  logic [DW-1:0] datain7,
    input  logic [DW-1:0] datain8,
    input  logic [DW-1:0] datain9,
    input  logic [DW-1:0] datain10,
    input  logic [DW-1:0] datain11,
    input  logic [DW-1:0] datain12,
    input  logic [DW-1:0] datain13,
    input  logic [DW-1:0] datain14,
    input  logic [DW-1:0] datain15,
    input  logic [DW-1:0] datain16,
    input  logic [DW-1:0] datain17,
    input  logic [DW-1:0] datain18,
    input  logic [DW-1:0] datain19,
    input  logic [DW-1:0] datain20,
    input  logic [DW-1:0] datain21,
    input  logic [DW-1:0] datain22,
    input  logic [DW-1:0] datain23,
    input  logic [DW-1:0] datain24,
    input  logic [DW-1:0] datain25,
    input  logic [DW-1:0] datain26,
    input  logic [DW-1:0] datain27,
    input  logic [DW-1:0] datain28,
    input  logic [DW-1:0] datain29,
    input  logic [DW-1:0] datain30,
    input  logic [DW-1:0] datain31,
    input  logic          out_ready,
    output logic [DW-1:0] dataout,
    output logic          out_valid,
    output logic          frame_start,
    output logic          frame_end,
    output logic          busy,
    output logic          overrun
);

    localparam int unsigned NWORDS = 32;
    localparam int unsigned IW     = 5;

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    state_t          r_state;
    logic [IW-1:0]   r_idx;
    logic            r_overrun;
    logic [DW-1:0]   r_buf [NWORDS];

    logic [DW-1:0]   w_din [NWORDS];
    logic [IW-1:0]   w_addr;
    logic            w_beat;
    logic            w_last;
    logic            w_capture;

    // Gather the flat input ports into an indexable array
    assign w_din[0]  = datain0;
    assign w_din[1]  = datain1;
    assign w_din[2]  = datain2;
    assign w_din[3]  = datain3;
    assign w_din[4]  = datain4;
    assign w_din[5]  = datain5;
    assign w_din[6]  = datain6;
    assign w_din[7]  = datain7;
    assign w_din[8]  = datain8;
    assign w_din[9]  = datain9;
    assign w_din[10] = datain10;
    assign w_din[11] = datain11;
    assign w_din[12] = datain12;
    assign w_din[13] = datain13;
    assign w_din[14] = datain14;
    assign w_din[15] = datain15;
    assign w_din[16] = datain16;
    assign w_din[17] = datain17;
    assign w_din[18] = datain18;
    assign w_din[19] = datain19;
    assign w_din[20] = datain20;
    assign w_din[21] = datain21;
    assign w_din[22] = datain22;
    assign w_din[23] = datain23;
    assign w_din[24] = datain24;
    assign w_din[25] = datain25;
    assign w_din[26] = datain26;
    assign w_din[27] = datain27;
    assign w_din[28] = datain28;
    assign w_din[29] = datain29;
    assign w_din[30] = datain30;
    assign w_din[31] = datain31;

    // Beat index to buffer address; bit 4 selects the real/imaginary half
`ifdef FFT_SER_BITREV_EN
    assign w_addr = {r_idx[4], r_idx[0], r_idx[1], r_idx[2], r_idx[3]};
`else
    assign w_addr = r_idx;
`endif

    assign out_valid   = (r_state == S_SEND);
    assign busy        = out_valid;
    assign frame_start = out_valid & (r_idx == '0);
    assign frame_end   = out_valid & w_last;
    assign overrun     = r_overrun;
    assign dataout     = out_valid ? r_buf[w_addr] : '0;

    assign w_beat    = out_valid & out_ready;
    assign w_last    = (r_idx == IW'(NWORDS - 1));
    // Capture happens from IDLE or on the final beat (back-to-back frames)
    assign w_capture = load & (~out_valid | (w_beat & w_last));

    // Frame buffer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NWORDS; i++) begin
                r_buf[i] <= '0;
            end
        end else if (w_capture) begin
            for (int i = 0; i < NWORDS; i++) begin
                r_buf[i] <= w_din[i];
            end
        end
    end

    // Control FSM, beat counter and sticky overrun flag
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_idx     <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (load && !w_capture) begin
                r_overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (load) begin
                        r_idx   <= '0;
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_beat) begin
                        if (w_last) begin
                            r_idx <= '0;
                            if (!load) begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_idx <= r_idx + IW'(1);
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_serializer.sv
// ----------------------------------------------------------------------------
// tb_fft_serializer
//   Self-checking bench for fft_serializer. A queue-based reference holds the
//   words still owed downstream. Every cycle the DUT outputs are compared with
//   that queue. Directed frames pin known values; a randomized phase follows.
//   Honours FFT_SER_BITREV_EN in the same way as the design.
// ----------------------------------------------------------------------------
module tb_fft_serializer;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        load = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] din [32];
    logic [15:0] dataout;
    logic        out_valid, frame_start, frame_end, busy, overrun;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] q[$];
    logic        m_ovr = 1'b0;

    always #5 clk = ~clk;

    fft_serializer #(.DW(16)) dut (
        .clk(clk), .reset(reset), .load(load),
        .datain0(din[0]),   .datain1(din[1]),   .datain2(din[2]),   .datain3(din[3]),
        .datain4(din[4]),   .datain5(din[5]),   .datain6(din[6]),   .datain7(din[7]),
        .datain8(din[8]),   .datain9(din[9]),   .datain10(din[10]), .datain11(din[11]),
        .datain12(din[12]), .datain13(din[13]), .datain14(din[14]), .datain15(din[15]),
        .datain16(din[16]), .datain17(din[17]), .datain18(din[18]), .datain19(din[19]),
        .datain20(din[20]), .datain21(din[21]), .datain22(din[22]), .datain23(din[23]),
        .datain24(din[24]), .datain25(din[25]), .datain26(din[26]), .datain27(din[27]),
        .datain28(din[28]), .datain29(din[29]), .datain30(din[30]), .datain31(din[31]),
        .out_ready(out_ready), .dataout(dataout), .out_valid(out_valid),
        .frame_start(frame_start), .frame_end(frame_end), .busy(busy), .overrun(overrun)
    );

    // Emission order: beat k carries word map_idx(k)
    function automatic int map_idx(int k);
`ifdef FFT_SER_BITREV_EN
        int r;
        r = k & 16;
        for (int b = 0; b < 4; b++) begin
            if (((k >> b) & 1) != 0) r = r | (1 << (3 - b));
        end
        return r;
`else
        return k;
`endif
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference update for one clock edge, using the inputs held at that edge
    task automatic model_step();
        bit beat, last, accept;
        beat   = (q.size() != 0) && out_ready;
        last   = (q.size() == 1);
        accept = load && ((q.size() == 0) || (beat && last));
        if (load && !accept) m_ovr = 1'b1;
        if (beat) void'(q.pop_front());
        if (accept) begin
            for (int k = 0; k < 32; k++) q.push_back(din[map_idx(k)]);
        end
    endtask

    task automatic check_all();
        bit v;
        v = (q.size() != 0);
        chk("out_valid",   32'(out_valid),   32'(v));
        chk("busy",        32'(busy),        32'(v));
        chk("dataout",     32'(dataout),     v ? 32'(q[0]) : 32'd0);
        chk("frame_start", 32'(frame_start), 32'(q.size() == 32));
        chk("frame_end",   32'(frame_end),   32'(q.size() == 1));
        chk("overrun",     32'(overrun),     32'(m_ovr));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic fill(input logic [15:0] base);
        for (int k = 0; k < 32; k++) din[k] = base + 16'(k);
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        int cnt;
        fill(16'h0000);

        // Reset state
        #2;
        check_all();
        chk("reset_dataout", 32'(dataout), 32'd0);
        #1 reset = 1'b1;
        tick();

        // Plain stream with out_ready held high
        fill(16'h0100);
        load = 1'b1; out_ready = 1'b1;
        tick();
        load = 1'b0;
        chk("stream_w0", 32'(dataout), 32'h0100);
        chk("stream_fs", 32'(frame_start), 32'd1);
        tick();
`ifdef FFT_SER_BITREV_EN
        chk("stream_w1", 32'(dataout), 32'h0108);
`else
        chk("stream_w1", 32'(dataout), 32'h0101);
`endif
        repeat (30) tick();
        chk("stream_w31", 32'(dataout), 32'h011F);
        chk("stream_fe",  32'(frame_end), 32'd1);
        tick();
        chk("stream_idle", 32'(out_valid), 32'd0);

        // Backpressure: ready low for three cycles at beat 5
        fill(16'h0100);
        load = 1'b1;
        tick();
        load = 1'b0;
        cnt = 1;
        repeat (5) begin tick(); cnt++; end
        out_ready = 1'b0;
        repeat (3) begin
            tick(); cnt++;
`ifdef FFT_SER_BITREV_EN
            chk("bp_hold", 32'(dataout), 32'h010A);
`else
            chk("bp_hold", 32'(dataout), 32'h0105);
`endif
        end
        out_ready = 1'b1;
        tick(); cnt++;
        chk("bp_resume", 32'(dataout), 32'h0106);
        while (!frame_end && cnt < 100) begin tick(); cnt++; end
        chk("bp_cycles", 32'(cnt), 32'd35);
        tick();

        // Back-to-back: second load on the final beat
        fill(16'h0100);
        load = 1'b1;
        tick();
        load = 1'b0;
        repeat (31) tick();
        fill(16'h0200);
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("b2b_w0", 32'(dataout), 32'h0200);
        chk("b2b_fs", 32'(frame_start), 32'd1);
        chk("b2b_ovr", 32'(overrun), 32'd0);
        repeat (32) tick();

        // Overrun: load mid-frame is dropped
        fill(16'h0100);
        load = 1'b1;
        tick();
        load = 1'b0;
        repeat (10) tick();
        fill(16'h0300);
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("ovr_flag", 32'(overrun), 32'd1);
`ifdef FFT_SER_BITREV_EN
        chk("ovr_w11", 32'(dataout), 32'h010D);
`else
        chk("ovr_w11", 32'(dataout), 32'h010B);
`endif
        repeat (21) tick();
        chk("ovr_sticky", 32'(overrun), 32'd1);

        // Most negative value passes bit-exact
        fill(16'h0100);
        din[0] = 16'h8000;
        load = 1'b1;
        tick();
        load = 1'b0;
        chk("signed_w0", 32'(dataout), 32'h8000);
        repeat (32) tick();

        // Reset in the middle of a frame
        fill(16'h0100);
        load = 1'b1;
        tick();
        load = 1'b0;
        repeat (4) tick();
        #2 reset = 1'b0;
        #1;
        chk("rst_valid",   32'(out_valid), 32'd0);
        chk("rst_dataout", 32'(dataout),   32'd0);
        chk("rst_overrun", 32'(overrun),   32'd0);
        q.delete();
        m_ovr = 1'b0;
        repeat (2) @(posedge clk);
        #3 reset = 1'b1;
        repeat (3) tick();
        chk("rst_quiet", 32'(out_valid), 32'd0);

        // Randomized load / backpressure / data
        for (int c = 0; c < 3000; c++) begin
            load      = ($urandom_range(0, 15) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < 32; k++) din[k] = 16'($urandom);
            tick();
        end
        load = 1'b0;
        out_ready = 1'b1;
        repeat (40) tick();
        chk("final_idle", 32'(out_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
